cr_tlvp_ord_merge: RTL and testbench

Reorders and merges the two TLV streams produced by the TLV parser splitter once they have been processed: the pass-through path (PASS/REP TLVs, unmodified) and the user path (TLVs returned by user logic, including replacements). Each TLV carries the order number stamped by the splitter. The block emits TLVs in ascending order number per frame. A user-path TLV replaces a pass-through TLV with the same order number. The output feeds the TLV builder.

---
 rtl/cr_tlvp_ord_merge_pkg.sv | 28 ++
 rtl/cr_tlvp_ord_merge.sv | 132 +++++++++++++
 tb/tb_cr_tlvp_ord_merge.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/cr_tlvp_ord_merge_pkg.sv
// Shared types for the TLV order merge block.
//   TLVP_ORD_NUM_WIDTH : order-number width (overridable from the command line).
//   tlvp_if_bus_t      : TLV bus word; the merge uses ordern, eot and tlast.
//   tlvp_merge_st_e    : merge FSM states.
`ifndef TLVP_ORD_NUM_WIDTH
`define TLVP_ORD_NUM_WIDTH 8
`endif

package cr_tlvp_ord_merge_pkg;

  localparam int unsigned TlvpOrdNumWidth = `TLVP_ORD_NUM_WIDTH;
  localparam int unsigned TlvpDataWidth   = 32;

  typedef struct packed {
    logic [TlvpDataWidth-1:0]   tdata;
    logic [TlvpOrdNumWidth-1:0] ordern;
    logic                       eot;
    logic                       tlast;
  } tlvp_if_bus_t;

  typedef enum logic [1:0] {
    StSel,
    StFwdUsr,
    StFwdPt,
    StDropPt
  } tlvp_merge_st_e;

endpackage

// File: rtl/cr_tlvp_ord_merge.sv
// Merges the pass-through and user TLV streams back into ascending order-number
// order per frame. A user TLV replaces the pass-through TLV with the same ordern.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   pt_empty/pt_rdata/pt_rd    pass-through FIFO head and pop
//   usr_empty/usr_rdata/usr_rd user FIFO head and pop
//   out_valid/out_data/out_ready registered merged output with backpressure
//   ord_err                one-cycle pulse on order resync
//
// Optional feature macro: CR_TLVP_ORD_MERGE_RESYNC_EN
//   When defined, SEL resynchronises exp_ord to the smaller head ordern if both
//   heads are valid and neither matches; ord_err exists only in that build.
`ifndef TLVP_ORD_NUM_WIDTH
`define TLVP_ORD_NUM_WIDTH 8
`endif

module cr_tlvp_ord_merge
  import cr_tlvp_ord_merge_pkg::*;
#(
  parameter int unsigned ORD_W = `TLVP_ORD_NUM_WIDTH
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         pt_empty,
  input  tlvp_if_bus_t pt_rdata,
  output logic         pt_rd,
  input  logic         usr_empty,
  input  tlvp_if_bus_t usr_rdata,
  output logic         usr_rd,
  output logic         out_valid,
  output tlvp_if_bus_t out_data,
  input  logic         out_ready
`ifdef CR_TLVP_ORD_MERGE_RESYNC_EN
  ,
  output logic         ord_err
`endif
);

  tlvp_merge_st_e   state_q;
  logic [ORD_W-1:0] exp_ord_q;

  logic             adv;
  logic             usr_hit;
  logic             pt_hit;
  logic             usr_pop;
  logic             pt_fwd;
  logic             pt_drop;
  logic [ORD_W-1:0] usr_ord_nxt;
  logic [ORD_W-1:0] pt_ord_nxt;
`ifdef CR_TLVP_ORD_MERGE_RESYNC_EN
  logic [ORD_W-1:0] ord_min;
`endif

  always_comb begin
    adv     = ~out_valid | out_ready;
    usr_hit = ~usr_empty & (usr_rdata.ordern == exp_ord_q);
    pt_hit  = ~pt_empty & (pt_rdata.ordern == exp_ord_q);
    usr_pop = (state_q == StFwdUsr) & adv & ~usr_empty;
    pt_fwd  = (state_q == StFwdPt) & adv & ~pt_empty;
    // Dropping produces no output, so it does not wait for the output register.
    pt_drop = (state_q == StDropPt) & ~pt_empty;
    usr_rd  = usr_pop;
    pt_rd   = pt_fwd | pt_drop;
    // Frame end restarts numbering at 1; otherwise increment with natural wrap.
    usr_ord_nxt = usr_rdata.tlast ? ORD_W'(1) : exp_ord_q + ORD_W'(1);
    pt_ord_nxt  = pt_rdata.tlast ? ORD_W'(1) : exp_ord_q + ORD_W'(1);
`ifdef CR_TLVP_ORD_MERGE_RESYNC_EN
    ord_min = (pt_rdata.ordern < usr_rdata.ordern) ? pt_rdata.ordern : usr_rdata.ordern;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StSel;
      exp_ord_q <= ORD_W'(1);
      out_valid <= 1'b0;
      out_data  <= '0;
`ifdef CR_TLVP_ORD_MERGE_RESYNC_EN
      ord_err   <= 1'b0;
`endif
    end else begin
`ifdef CR_TLVP_ORD_MERGE_RESYNC_EN
      ord_err <= 1'b0;
`endif
      if (adv) begin
        out_valid <= usr_pop | pt_fwd;
      end
      // out_data only changes on a pop, so it is stable under backpressure.
      if (usr_pop) begin
        out_data <= usr_rdata;
      end else if (pt_fwd) begin
        out_data <= pt_rdata;
      end

      unique case (state_q)
        StSel: begin
          if (usr_hit) begin
            state_q <= StFwdUsr;
          end else if (pt_hit) begin
            state_q <= StFwdPt;
`ifdef CR_TLVP_ORD_MERGE_RESYNC_EN
          end else if (~usr_empty & ~pt_empty) begin
            exp_ord_q <= ord_min;
            ord_err   <= 1'b1;
`endif
          end
        end
        StFwdUsr: begin
          if (usr_pop & usr_rdata.eot) begin
            exp_ord_q <= usr_ord_nxt;
            // A pt TLV still carrying the current ordern is the replaced original.
            state_q   <= pt_hit ? StDropPt : StSel;
          end
        end
        StFwdPt: begin
          if (pt_fwd & pt_rdata.eot) begin
            exp_ord_q <= pt_ord_nxt;
            state_q   <= StSel;
          end
        end
        StDropPt: begin
          if (pt_drop & pt_rdata.eot) begin
            state_q <= StSel;
          end
        end
        default: state_q <= StSel;
      endcase
    end
  end

endmodule

// File: tb/tb_cr_tlvp_ord_merge.sv
module tb_cr_tlvp_ord_merge;
  import cr_tlvp_ord_merge_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         pt_empty;
  tlvp_if_bus_t pt_rdata;
  logic         pt_rd;
  logic         usr_empty;
  tlvp_if_bus_t usr_rdata;
  logic         usr_rd;
  logic         out_valid;
  tlvp_if_bus_t out_data;
  logic         out_ready;
`ifdef CR_TLVP_ORD_MERGE_RESYNC_EN
  logic         ord_err;
`endif

  int checks   = 0;
  int failures = 0;

  // FIFO models: memories written by the stimulus, read pointers advanced on pops.
  tlvp_if_bus_t pt_mem  [0:63];
  tlvp_if_bus_t usr_mem [0:63];
  int pt_wp  = 0;
  int usr_wp = 0;
  int pt_rp  = 0;
  int usr_rp = 0;

  tlvp_if_bus_t cap [0:127];
  int cap_n = 0;

  assign pt_empty  = (pt_rp == pt_wp);
  assign usr_empty = (usr_rp == usr_wp);
  assign pt_rdata  = pt_mem[pt_rp[5:0]];
  assign usr_rdata = usr_mem[usr_rp[5:0]];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pt_rd) pt_rp <= pt_rp + 1;
    if (usr_rd) usr_rp <= usr_rp + 1;
    if (rst_n && out_valid && out_ready) begin
      cap[cap_n[6:0]] = out_data;
      cap_n = cap_n + 1;
    end
  end

  cr_tlvp_ord_merge dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pt_empty  (pt_empty),
    .pt_rdata  (pt_rdata),
    .pt_rd     (pt_rd),
    .usr_empty (usr_empty),
    .usr_rdata (usr_rdata),
    .usr_rd    (usr_rd),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready)
`ifdef CR_TLVP_ORD_MERGE_RESYNC_EN
    ,
    .ord_err   (ord_err)
`endif
  );

  function automatic logic [31:0] mk(input int src, input int ordn, input int idx);
    return {8'(src), 8'(ordn), 16'(idx)};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // src 1 = pass-through, 2 = user; tlast goes on the final word when last is set.
  task automatic push(input int src, input int ordn, input int nw, input bit last);
    tlvp_if_bus_t w;
    for (int i = 0; i < nw; i++) begin
      w.tdata  = mk(src, ordn, i);
      w.ordern = TlvpOrdNumWidth'(ordn);
      w.eot    = (i == nw - 1);
      w.tlast  = last && (i == nw - 1);
      if (src == 1) begin
        pt_mem[pt_wp[5:0]] = w;
        pt_wp++;
      end else begin
        usr_mem[usr_wp[5:0]] = w;
        usr_wp++;
      end
    end
  endtask

  task automatic wait_caps(input int target, input int budget, input string tag);
    int n = 0;
    while (cap_n < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_timeout"}, 64'(cap_n >= target), 64'd1);
  endtask

  task automatic check_word(input string tag, input int k, input logic [31:0] exp);
    check(tag, 64'(cap[k[6:0]].tdata), 64'(exp));
  endtask

  initial begin
    int base;
    rst_n     = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_pt_rd", 64'(pt_rd), 64'd0);
    check("rst_usr_rd", 64'(usr_rd), 64'd0);
    check("rst_state", 64'(dut.state_q), 64'(StSel));
    check("rst_exp_ord", 64'(dut.exp_ord_q), 64'd1);
`ifdef CR_TLVP_ORD_MERGE_RESYNC_EN
    check("rst_ord_err", 64'(ord_err), 64'd0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    // PASS only: ordern 1,2,3 of two words each, frame ends on ordern 3
    base = cap_n;
    push(1, 1, 2, 1'b0);
    push(1, 2, 2, 1'b0);
    push(1, 3, 2, 1'b1);
    wait_caps(base + 6, 100, "pass");
    for (int o = 1; o <= 3; o++) begin
      for (int i = 0; i < 2; i++) begin
        check_word("pass_word", base + (o - 1) * 2 + i, mk(1, o, i));
      end
    end
    check("pass_tlast", 64'(cap[(base + 5) % 128].tlast), 64'd1);
    check("pass_exp_ord", 64'(dut.exp_ord_q), 64'd1);
    check("pass_pt_drained", 64'(pt_rp), 64'(pt_wp));

    // REP: user ordern 1 (3 words) replaces pt ordern 1 (2 words)
    base = cap_n;
    push(1, 1, 2, 1'b0);
    push(1, 2, 1, 1'b1);
    push(2, 1, 3, 1'b0);
    wait_caps(base + 4, 100, "rep");
    for (int i = 0; i < 3; i++) check_word("rep_usr_word", base + i, mk(2, 1, i));
    check_word("rep_pt_word", base + 3, mk(1, 2, 0));
    repeat (4) @(negedge clk);
    check("rep_count", 64'(cap_n - base), 64'd4);
    check("rep_pt_drained", 64'(pt_rp), 64'(pt_wp));
    check("rep_usr_drained", 64'(usr_rp), 64'(usr_wp));
    check("rep_exp_ord", 64'(dut.exp_ord_q), 64'd1);

    // Interleave: pt 1 and 3 present, user 2 arrives late -> stall in SEL
    base = cap_n;
    push(1, 1, 1, 1'b0);
    push(1, 3, 1, 1'b1);
    wait_caps(base + 1, 50, "ilv_first");
    repeat (6) @(negedge clk);
    check("ilv_stall_count", 64'(cap_n - base), 64'd1);
    check("ilv_stall_state", 64'(dut.state_q), 64'(StSel));
    check("ilv_stall_exp_ord", 64'(dut.exp_ord_q), 64'd2);
    push(2, 2, 2, 1'b0);
    wait_caps(base + 4, 100, "ilv");
    check_word("ilv_w0", base, mk(1, 1, 0));
    check_word("ilv_w1", base + 1, mk(2, 2, 0));
    check_word("ilv_w2", base + 2, mk(2, 2, 1));
    check_word("ilv_w3", base + 3, mk(1, 3, 0));
    check("ilv_exp_ord", 64'(dut.exp_ord_q), 64'd1);

    // Backpressure: ready 1,0,0,1 across a 4-word TLV
    base = cap_n;
    push(1, 1, 4, 1'b1);
    begin
      int n = 0;
      while (!out_valid && n < 50) begin
        @(negedge clk);
        n++;
      end
    end
    check("bp_first_valid", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_load_w1", 64'(out_data.tdata), 64'(mk(1, 1, 1)));
    @(negedge clk);
    check("bp_stall1_data", 64'(out_data.tdata), 64'(mk(1, 1, 1)));
    check("bp_stall1_valid", 64'(out_valid), 64'd1);
    check("bp_stall1_pt_rd", 64'(pt_rd), 64'd0);
    @(negedge clk);
    check("bp_stall2_data", 64'(out_data.tdata), 64'(mk(1, 1, 1)));
    out_ready = 1'b1;
    wait_caps(base + 4, 50, "bp");
    repeat (4) @(negedge clk);
    check("bp_count", 64'(cap_n - base), 64'd4);
    for (int i = 0; i < 4; i++) check_word("bp_word", base + i, mk(1, 1, i));
    check("bp_exp_ord", 64'(dut.exp_ord_q), 64'd1);

`ifdef CR_TLVP_ORD_MERGE_RESYNC_EN
    // Resync: exp_ord=1, pt head 4, usr head 6 -> jump to 4, forward pt
    base = cap_n;
    push(1, 4, 1, 1'b0);
    push(2, 6, 1, 1'b0);
    @(negedge clk);
    check("rsy_ord_err_pulse", 64'(ord_err), 64'd1);
    check("rsy_exp_ord", 64'(dut.exp_ord_q), 64'd4);
    @(negedge clk);
    check("rsy_ord_err_clear", 64'(ord_err), 64'd0);
    wait_caps(base + 1, 50, "rsy");
    check_word("rsy_word", base, mk(1, 4, 0));
`endif

    // Async reset in the middle of a TLV
    base = cap_n;
    push(1, 1, 3, 1'b0);
    wait_caps(base + 1, 50, "arst");
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_out_data", 64'(out_data), 64'd0);
    check("arst_pt_rd", 64'(pt_rd), 64'd0);
    check("arst_usr_rd", 64'(usr_rd), 64'd0);
    check("arst_state", 64'(dut.state_q), 64'(StSel));
    check("arst_exp_ord", 64'(dut.exp_ord_q), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
